consec_run_logger: RTL and testbench
====================================

# consec_run_logger

Downstream consumer of the consecutive-ones detector. Samples the detector's newest serial bit and its 4-in-a-row flag every CLK, measures the full length of every run of ones that reaches at least four, and queues one record per qualifying run (length, starting lane, saturation flag) in a small FIFO. A valid/ready port drains the records. Totals and drop counts are kept for observability.

## Interface
- LEN_W, 8, width of the run-length field; the length saturates at 2^LEN_W-1.
- DEPTH, 4, number of record FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the qualified-run total counter.

Ports:
- CLK  in  1  the single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- bit_in  in  1  newest serial bit from the detector shift register.
- consec_in  in  1  detector flag, high when the last 4 sampled bits (including bit_in) are 1.
- sel_in  in  2  lane select value accompanying bit_in.
- evt_ready  in  1  sink ready.
- evt_valid  out  1  FIFO non-empty.
- evt_len  out  LEN_W  head record run length.
- evt_lane  out  2  head record start lane.
- evt_sat  out  1  head record length saturated.
- fifo_full  out  1  FIFO holds DEPTH records.
- drop_cnt  out  8  records lost to a full FIFO; saturates at 255.
- run_total  out  CNT_W  qualified runs detected; wraps.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states are IDLE, RUN and QUAL. Each transition below is evaluated on a rising CLK using the sampled bit_in and consec_in.
- IDLE:
  - bit_in=1 → RUN, with run_len=1 and start_lane=sel_in.
  - bit_in=0 → stay in IDLE.
- RUN:
  - bit_in=1 and consec_in=1 → QUAL, run_len+1, run_total+1.
  - bit_in=1 and consec_in=0 → stay in RUN, run_len+1.
  - bit_in=0 → IDLE. The short run is discarded and run_len=0.
- QUAL:
  - bit_in=1 → stay in QUAL, run_len+1 (saturating). consec_in is don't-care.
  - bit_in=0 → push {run_len, start_lane, sat} into the FIFO, go to IDLE, run_len=0.
- consec_in is ignored whenever bit_in=0, and whenever the FSM is in IDLE or QUAL.
- Saturation: run_len stops at 2^LEN_W-1. sat is set once an increment is attempted at max; it is cleared on IDLE.
- FIFO is show-ahead. evt_len, evt_lane and evt_sat reflect the head entry whenever evt_valid=1, and are 0 when the FIFO is empty.
- Pop occurs when evt_valid and evt_ready are both 1 at the edge. Data must stay stable while evt_valid=1 and evt_ready=0.
- Push when full and no pop: the record is dropped and drop_cnt increments (saturating).
- Push when full with a simultaneous pop: the push is accepted, the occupancy stays DEPTH, and there is no drop.
- Push and pop together when not full: the occupancy is unchanged.
- run_total wraps from 2^CNT_W-1 to 0.
- Pointers are log2(DEPTH) bits plus one wrap bit. full/empty come from a pointer compare.

## Timing
- RST asserted clears everything immediately, without waiting for CLK:
  - FSM=IDLE, run_len=0, FIFO empty.
  - drop_cnt=0 and run_total=0.
  - All outputs are 0.
  - An in-progress run is discarded with no record.
- Latency: the edge that samples the terminating bit_in=0 writes the record. If the FIFO was empty, evt_valid goes high right after that edge, so 1 cycle after the 0 is presented.
- run_total increments on the edge that enters QUAL; this is the edge sampling the 4th consecutive 1.
- fifo_full and evt_valid are registered-state derived, with no combinational path from evt_ready.
- Back-to-back runs are supported: a run ending in cycle n and a new 1 in cycle n+1 is a new run. Throughput is at most one record per 5 cycles.
- A run that is still open when RST is released is not recognised. The first 1 sampled after release starts a new run.

## Test plan
- Reset: hold RST mid-stream with FIFO contents present → all outputs are 0 asynchronously. After release, evt_valid=0 until a new qualified run completes.
- Basic run:
  - Stimulus: bit_in 0,1,1,1,1,1,0 with consec_in high on the 4th and 5th ones, sel_in=2 on the first one, evt_ready=1.
  - Response: a single evt_valid pulse with evt_len=5, evt_lane=2, evt_sat=0; run_total=1.
- Short run: bit_in 1,1,1,0 with consec_in=0 → no record, run_total unchanged, busy high for 3 cycles.
- Overflow and drain (DEPTH=4):
  - Stimulus: evt_ready=0, then five qualified runs of lengths 4, 5, 6, 7, 8.
  - Response: fifo_full after the 4th run, the 8 is dropped, drop_cnt=1.
  - Then evt_ready=1 → evt_len reads 4, 5, 6, 7 on consecutive cycles, then evt_valid=0.
- Full with simultaneous pop: with the FIFO full, assert evt_ready in the same cycle a run terminates → the push is accepted, drop_cnt unchanged, fifo_full stays 1.
- Saturation and reset mid-QUAL:
  - A run of 300 ones → record evt_len=255, evt_sat=1.
  - RST pulsed during a run in QUAL → no record and run_total=0.

Source files
------------

// File: rtl/consec_run_logger.sv
// consec_run_logger: measures every run of ones that reaches the detector's
// 4-in-a-row threshold and queues one {length, start lane, saturated} record
// per run in a show-ahead FIFO drained over a valid/ready port.
module consec_run_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bit_in,
  input  logic             consec_in,
  input  logic [1:0]       sel_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [LEN_W-1:0] evt_len,
  output logic [1:0]       evt_lane,
  output logic             evt_sat,
  output logic             fifo_full,
  output logic [7:0]       drop_cnt,
  output logic [CNT_W-1:0] run_total,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_QUAL = 2'd2;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [1:0]       lane;
    logic             sat;
  } rec_t;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       lane_q, lane_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic [7:0]       drop_q;
  logic [AW:0]      wr_q, rd_q;
  rec_t             mem_q [DEPTH];

  logic len_max, push, pop, empty, full, wr_en, drop;
  rec_t head;

  assign len_max = &len_q;

  // Run tracking FSM: length counts every one of the run, including the
  // ones seen before the detector qualified it.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lane_d  = lane_q;
    sat_d   = sat_q;
    tot_d   = tot_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bit_in) begin
          state_d = S_RUN;
          len_d   = LEN_W'(1);
          lane_d  = sel_in;
          sat_d   = 1'b0;
        end
      end
      S_RUN, S_QUAL: begin
        if (bit_in) begin
          len_d = len_max ? len_q : len_q + LEN_W'(1);
          sat_d = sat_q | len_max;
          if (state_q == S_RUN && consec_in) begin
            state_d = S_QUAL;
            tot_d   = tot_q + CNT_W'(1);
          end
        end else begin
          // Only a qualified run leaves a record; short runs vanish.
          push    = (state_q == S_QUAL);
          state_d = S_IDLE;
          len_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and run registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lane_q  <= '0;
      sat_q   <= 1'b0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      sat_q   <= sat_d;
      tot_q   <= tot_d;
    end
  end

  // Pointer-compare FIFO flags; a pop frees the slot a same-cycle push needs.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && evt_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO pointers and drop counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  // Record storage; contents are only visible through a valid head.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= '{len: len_q, lane: lane_q, sat: sat_q};
  end

  assign head      = mem_q[rd_q[AW-1:0]];
  assign evt_valid = !empty;
  assign evt_len   = empty ? '0 : head.len;
  assign evt_lane  = empty ? '0 : head.lane;
  assign evt_sat   = empty ? 1'b0 : head.sat;
  assign fifo_full = full;
  assign drop_cnt  = drop_q;
  assign run_total = tot_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_consec_run_logger.sv
// Bench for consec_run_logger: a vector table for the basic and short runs,
// plus hand-written sequences for overflow, full+pop, saturation and reset.
module tb_consec_run_logger;

  logic        CLK = 1'b0;
  logic        RST;
  logic        bit_in, consec_in, evt_ready;
  logic [1:0]  sel_in;
  logic        evt_valid, evt_sat, fifo_full, busy;
  logic [7:0]  evt_len, drop_cnt;
  logic [1:0]  evt_lane;
  logic [15:0] run_total;

  consec_run_logger #(.LEN_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .bit_in(bit_in), .consec_in(consec_in),
    .sel_in(sel_in), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_len(evt_len), .evt_lane(evt_lane), .evt_sat(evt_sat),
    .fifo_full(fifo_full), .drop_cnt(drop_cnt), .run_total(run_total),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {int len; int lane; int sat;} exp_t;
  typedef struct {int b; int c; int s; int r; int eb; int ev; int et;
                  int sb; int sl; int sn;} vec_t;

  exp_t q[$];
  vec_t tbl[12];
  int checks = 0;
  int errors = 0;
  int exp_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // n ones (detector flag from the 4th on), then the terminating zero.
  task automatic run_seq(input int n, input logic [1:0] lane, input bit rec,
                         input logic rdy_end);
    for (int i = 0; i < n; i++) begin
      bit_in    = 1'b1;
      consec_in = (i >= 3);
      sel_in    = (i == 0) ? lane : 2'($urandom_range(0, 3));
      step();
    end
    if (n >= 4) exp_tot++;
    if (rec) q.push_back('{(n > 255) ? 255 : n, int'(lane), (n > 255) ? 1 : 0});
    bit_in    = 1'b0;
    consec_in = 1'b0;
    evt_ready = rdy_end;
    step();
  endtask

  task automatic idle(input int n);
    bit_in = 1'b0; consec_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard: a pop happens at the next edge when valid and ready are high.
  always @(negedge CLK) begin
    if (!RST && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual_len=%0d expected=no record", evt_len);
      end else begin
        chk("pop_len", evt_len, q[0].len);
        chk("pop_lane", evt_lane, q[0].lane);
        chk("pop_sat", evt_sat, q[0].sat);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    //          b c s r  busy vld tot sb len lane
    tbl[0]  = '{0,0,0,1, 0,0,0, 0,0,0};
    tbl[1]  = '{1,0,2,1, 1,0,0, 0,0,0};
    tbl[2]  = '{1,0,0,1, 1,0,0, 0,0,0};
    tbl[3]  = '{1,0,0,1, 1,0,0, 0,0,0};
    tbl[4]  = '{1,1,0,1, 1,0,1, 0,0,0};
    tbl[5]  = '{1,1,0,1, 1,0,1, 0,0,0};
    tbl[6]  = '{0,0,0,1, 0,1,1, 1,5,2};
    tbl[7]  = '{0,0,0,1, 0,0,1, 0,0,0};
    tbl[8]  = '{1,0,1,1, 1,0,1, 0,0,0};
    tbl[9]  = '{1,0,0,1, 1,0,1, 0,0,0};
    tbl[10] = '{1,0,0,1, 1,0,1, 0,0,0};
    tbl[11] = '{0,0,0,1, 0,0,1, 0,0,0};

    RST = 1'b1; bit_in = 1'b0; consec_in = 1'b0; sel_in = 2'd0; evt_ready = 1'b1;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_total", run_total, 0);
    step(); step();
    RST = 1'b0;

    // Basic run then short run
    for (int i = 0; i < 12; i++) begin
      bit_in    = 1'(tbl[i].b);
      consec_in = 1'(tbl[i].c);
      sel_in    = 2'(tbl[i].s);
      evt_ready = 1'(tbl[i].r);
      if (tbl[i].sb != 0) q.push_back('{tbl[i].sl, tbl[i].sn, 0});
      step();
      chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("v%0d_valid", i), evt_valid, tbl[i].ev);
      chk($sformatf("v%0d_total", i), run_total, tbl[i].et);
    end
    exp_tot = 1;

    // Saturation: 300 ones
    run_seq(300, 2'd1, 1'b1, 1'b1);
    idle(2);
    chk("sat_total", run_total, exp_tot);
    chk("sat_drained", evt_valid, 0);

    // Overflow: four records fill, fifth dropped, then drain
    evt_ready = 1'b0;
    run_seq(4, 2'd0, 1'b1, 1'b0);
    run_seq(5, 2'd1, 1'b1, 1'b0);
    run_seq(6, 2'd2, 1'b1, 1'b0);
    chk("ovf_not_full", fifo_full, 0);
    run_seq(7, 2'd3, 1'b1, 1'b0);
    chk("ovf_full", fifo_full, 1);
    run_seq(8, 2'd0, 1'b0, 1'b0);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_full2", fifo_full, 1);
    chk("ovf_head", evt_len, 4);
    evt_ready = 1'b1;
    idle(4);
    chk("ovf_empty", evt_valid, 0);
    chk("ovf_total", run_total, exp_tot);

    // Full FIFO with a pop on the terminating edge
    evt_ready = 1'b0;
    run_seq(4, 2'd1, 1'b1, 1'b0);
    run_seq(5, 2'd2, 1'b1, 1'b0);
    run_seq(6, 2'd3, 1'b1, 1'b0);
    run_seq(7, 2'd0, 1'b1, 1'b0);
    chk("fp_full_before", fifo_full, 1);
    run_seq(9, 2'd2, 1'b1, 1'b1);
    chk("fp_full_after", fifo_full, 1);
    chk("fp_drop", drop_cnt, 1);
    chk("fp_head", evt_len, 5);
    idle(4);
    chk("fp_empty", evt_valid, 0);
    chk("fp_total", run_total, exp_tot);

    // Asynchronous reset during QUAL with a record queued
    evt_ready = 1'b0;
    run_seq(5, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bit_in = 1'b1; consec_in = (i >= 3); sel_in = 2'd1;
      step();
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", evt_valid, 1);
    #2;
    RST = 1'b1;
    #1;
    q.delete();
    exp_tot = 0;
    chk("arst_valid", evt_valid, 0);
    chk("arst_len", evt_len, 0);
    chk("arst_lane", evt_lane, 0);
    chk("arst_sat", evt_sat, 0);
    chk("arst_full", fifo_full, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_total", run_total, 0);
    chk("arst_busy", busy, 0);
    step(); step();
    bit_in = 1'b0; consec_in = 1'b0;
    RST = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", evt_valid, 0);
    chk("post_rst_total", run_total, 0);
    evt_ready = 1'b1;
    run_seq(4, 2'd2, 1'b1, 1'b1);
    idle(2);
    chk("post_rst_run_total", run_total, exp_tot);
    chk("post_rst_empty", evt_valid, 0);

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
